// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter: two-client request/grant pixel sequencer for a 160x120
// VGA adapter. Each granted job rasterises one rectangle, one pixel per clock.
// Optional erase pass of the client's previous rectangle: define SPRITE_ERASE_EN.
module sprite_draw_arbiter #(
    parameter int         XMAX      = 160,
    parameter int         YMAX      = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [3:0] w0,
    input  logic [3:0] w1,
    input  logic [2:0] h0,
    input  logic [2:0] h1,
    input  logic [2:0] colour0,
    input  logic [2:0] colour1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [8:0] XLIM = 9'(XMAX);
    localparam logic [7:0] YLIM = 8'(YMAX);

    state_t     state;
    logic       owner;
    logic       ptr;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [3:0] lw;
    logic [2:0] lh;
    logic [2:0] lcol;
    logic [3:0] cx;
    logic [2:0] cy;

    logic       pick1;
    logic       start_erase;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic [3:0] scan_w;
    logic [2:0] scan_h;
    logic [8:0] px;
    logic [7:0] py;
    logic       row_end;
    logic       last_pix;

`ifdef SPRITE_ERASE_EN
    logic [7:0] prev_x [2];
    logic [6:0] prev_y [2];
    logic [3:0] prev_w [2];
    logic [2:0] prev_h [2];
    logic [1:0] erase_valid;
`endif

    // Arbitration choice and the rectangle currently being scanned
    always_comb begin
        pick1       = req1 & (~req0 | ptr);
        start_erase = 1'b0;
        scan_x      = lx;
        scan_y      = ly;
        scan_w      = lw;
        scan_h      = lh;
`ifdef SPRITE_ERASE_EN
        start_erase = erase_valid[pick1];
        if (state == ERASE) begin
            scan_x = prev_x[owner];
            scan_y = prev_y[owner];
            scan_w = prev_w[owner];
            scan_h = prev_h[owner];
        end
`endif
        px       = {1'b0, scan_x} + {5'b0, cx};
        py       = {1'b0, scan_y} + {5'b0, cy};
        row_end  = (cx == scan_w);
        last_pix = row_end && (cy == scan_h);
    end

    // Job sequencer; pixel outputs are registered one cycle behind the scan counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            ptr        <= 1'b0;
            lx         <= '0;
            ly         <= '0;
            lw         <= '0;
            lh         <= '0;
            lcol       <= '0;
            cx         <= '0;
            cy         <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
`ifdef SPRITE_ERASE_EN
            erase_valid <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                prev_x[i] <= '0;
                prev_y[i] <= '0;
                prev_w[i] <= '0;
                prev_h[i] <= '0;
            end
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                    if (req0 || req1) begin
                        owner <= pick1;
                        lx    <= pick1 ? x1 : x0;
                        ly    <= pick1 ? y1 : y0;
                        lw    <= pick1 ? w1 : w0;
                        lh    <= pick1 ? h1 : h0;
                        lcol  <= pick1 ? colour1 : colour0;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        cx    <= '0;
                        cy    <= '0;
                        state <= start_erase ? ERASE : DRAW;
                    end
                end
                ERASE, DRAW: begin
                    vga_x      <= px[7:0];
                    vga_y      <= py[6:0];
                    vga_colour <= (state == ERASE) ? BG_COLOUR : lcol;
                    vga_plot   <= (px < XLIM) && (py < YLIM);
                    if (last_pix) begin
                        cx    <= '0;
                        cy    <= '0;
                        state <= (state == ERASE) ? DRAW : DONE;
                    end else if (row_end) begin
                        cx <= '0;
                        cy <= cy + 3'd1;
                    end else begin
                        cx <= cx + 4'd1;
                    end
                end
                DONE: begin
                    vga_plot <= 1'b0;
                    done0    <= ~owner;
                    done1    <= owner;
                    ptr      <= ~owner;
`ifdef SPRITE_ERASE_EN
                    prev_x[owner]      <= lx;
                    prev_y[owner]      <= ly;
                    prev_w[owner]      <= lw;
                    prev_h[owner]      <= lh;
                    erase_valid[owner] <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Directed self-checking bench for sprite_draw_arbiter.
module tb_sprite_draw_arbiter;

    logic       clock;
    logic       resetn;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [3:0] w0, w1;
    logic [2:0] h0, h1;
    logic [2:0] colour0, colour1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int nplot = 0;

    sprite_draw_arbiter #(.XMAX(160), .YMAX(120), .BG_COLOUR(3'b000)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .w0(w0), .w1(w1), .h0(h0), .h1(h1),
        .colour0(colour0), .colour1(colour1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_x"}, vga_x, 0);
        chk({tag, "_y"}, vga_y, 0);
        chk({tag, "_col"}, vga_colour, 0);
        chk({tag, "_plot"}, vga_plot, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One negedge per pixel, row-major; plot expected only inside the 160x120 area
    task automatic expect_rect(input string tag, input int x, input int y,
                               input int w, input int h, input logic [2:0] col);
        int ex, ey;
        logic ep;
        for (int r = 0; r <= h; r++) begin
            for (int c = 0; c <= w; c++) begin
                @(negedge clock);
                ex = x + c;
                ey = y + r;
                ep = (ex < 160) && (ey < 120);
                chk({tag, "_plot"}, vga_plot, ep);
                chk({tag, "_busy"}, busy, 1);
                if (ep) begin
                    chk({tag, "_x"}, vga_x, ex);
                    chk({tag, "_y"}, vga_y, ey);
                    chk({tag, "_col"}, vga_colour, col);
                end
                if (vga_plot) nplot++;
            end
        end
    endtask

    task automatic set_req0(input int x, input int y, input int w, input int h, input int c);
        x0 = 8'(x); y0 = 7'(y); w0 = 4'(w); h0 = 3'(h); colour0 = 3'(c);
    endtask

    task automatic set_req1(input int x, input int y, input int w, input int h, input int c);
        x1 = 8'(x); y1 = 7'(y); w1 = 4'(w); h1 = 3'(h); colour1 = 3'(c);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        resetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        set_req0(0, 0, 0, 0, 0);
        set_req1(0, 0, 0, 0, 0);

        // Reset state
        @(negedge clock);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        // Single draw: 4x2 at (10,20), colour 010
        set_req0(10, 20, 3, 1, 2);
        req0 = 1'b1;
        @(negedge clock);
        chk("sd_gnt0", gnt0, 1);
        chk("sd_gnt1", gnt1, 0);
        chk("sd_busy", busy, 1);
        chk("sd_plot_gnt", vga_plot, 0);
        expect_rect("sd", 10, 20, 3, 1, 3'b010);
        @(negedge clock);
        chk("sd_done0", done0, 1);
        chk("sd_done1", done1, 0);
        chk("sd_plot_done", vga_plot, 0);
        req0 = 1'b0;
        @(negedge clock);
        chk("sd_done0_pulse", done0, 0);
        chk("sd_no_regrant", gnt0, 0);
        chk("sd_busy_after", busy, 0);

        // Request dropped two cycles after grant still completes
        set_req0(30, 40, 1, 1, 4);
        req0 = 1'b1;
        @(negedge clock);
        chk("rd_gnt0", gnt0, 1);
        expect_rect("rd_row0", 30, 40, 1, 0, 3'd4);
        req0 = 1'b0;
        set_req0(99, 99, 5, 5, 1);
        expect_rect("rd_row1", 30, 41, 1, 0, 3'd4);
        @(negedge clock);
        chk("rd_done0", done0, 1);
        @(negedge clock);
        chk("rd_idle", busy, 0);

        // Clipping at the bottom-right corner
        set_req1(158, 119, 3, 1, 7);
        req1 = 1'b1;
        @(negedge clock);
        chk("cl_gnt1", gnt1, 1);
        chk("cl_gnt0", gnt0, 0);
        nplot = 0;
        expect_rect("cl", 158, 119, 3, 1, 3'd7);
        chk("cl_nplot", nplot, 2);
        @(negedge clock);
        chk("cl_done1", done1, 1);
        chk("cl_done0", done0, 0);
        req1 = 1'b0;
        @(negedge clock);

        // Arbitration: simultaneous requests after reset alternate 0,1,0,1
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        set_req0(0, 0, 0, 0, 1);
        set_req1(1, 1, 0, 0, 5);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("ar_gnt0", gnt0, (k % 2 == 0));
            chk("ar_gnt1", gnt1, (k % 2 == 1));
            if (k % 2 == 0) expect_rect("ar_c0", 0, 0, 0, 0, 3'd1);
            else            expect_rect("ar_c1", 1, 1, 0, 0, 3'd5);
            @(negedge clock);
            chk("ar_done0", done0, (k % 2 == 0));
            chk("ar_done1", done1, (k % 2 == 1));
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge clock);
        chk("ar_end_gnt0", gnt0, 0);
        chk("ar_end_gnt1", gnt1, 0);
        chk("ar_end_busy", busy, 0);

`ifdef SPRITE_ERASE_EN
        // Erase pass removes the previous rectangle before redrawing
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        set_req0(5, 5, 1, 0, 6);
        req0 = 1'b1;
        @(negedge clock);
        chk("er_gnt_a", gnt0, 1);
        expect_rect("er_first", 5, 5, 1, 0, 3'd6);
        @(negedge clock);
        chk("er_done_a", done0, 1);
        set_req0(6, 5, 1, 0, 6);
        @(negedge clock);
        chk("er_gnt_b", gnt0, 1);
        expect_rect("er_erase", 5, 5, 1, 0, 3'd0);
        expect_rect("er_draw", 6, 5, 1, 0, 3'd6);
        @(negedge clock);
        chk("er_done_b", done0, 1);
        req0 = 1'b0;
        @(negedge clock);
`endif

        // Reset asserted mid-job
        set_req0(0, 0, 15, 7, 3);
        req0 = 1'b1;
        @(negedge clock);
        chk("mj_gnt0", gnt0, 1);
`ifdef SPRITE_ERASE_EN
        expect_rect("mj_erase", 6, 5, 1, 0, 3'd0);
`endif
        expect_rect("mj_draw", 0, 0, 1, 0, 3'd3);
        resetn = 1'b0;
        req0 = 1'b0;
        #1;
        chk_all_zero("mj_reset");
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("mj_no_done", done0, 0);
            chk("mj_idle", busy, 0);
        end
        set_req0(50, 50, 0, 0, 2);
        req0 = 1'b1;
        @(negedge clock);
        chk("mj_regnt", gnt0, 1);
        expect_rect("mj_post", 50, 50, 0, 0, 3'd2);
        @(negedge clock);
        chk("mj_post_done", done0, 1);
        req0 = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
